// File: rtl/remote_comm_if.sv
// Host-side bundle for the Knight command link: command strobe/word, UART lines and response status.
// The master modport is the host/bench side, the slave modport is the remote_comm block.
interface remote_comm_if;
    logic        snd_cmd;
    logic [15:0] cmd;
    logic        cmd_snt;
    logic        TX;
    logic        RX;
    logic [7:0]  resp;
    logic        resp_rdy;
    logic        clr_resp_rdy;
    logic        resp_timeout;

    modport master (
        output snd_cmd, cmd, RX, clr_resp_rdy,
        input  cmd_snt, TX, resp, resp_rdy, resp_timeout
    );

    modport slave (
        input  snd_cmd, cmd, RX, clr_resp_rdy,
        output cmd_snt, TX, resp, resp_rdy, resp_timeout
    );
endinterface

// File: rtl/remote_comm.sv
// Knight host command link: sends a 16-bit command as two 8N1 bytes (high first), captures a 1-byte reply.
// Optional response watchdog enabled by defining RESP_TIMEOUT_EN.
module remote_comm #(
    parameter int BAUD_DIV     = 2604,
    parameter int TIMEOUT_CLKS = 3000000
) (
    input  logic         clk,
    input  logic         rst_n,
    remote_comm_if.slave bus
);

    localparam int BCW = ($clog2(BAUD_DIV + 1) > 12) ? $clog2(BAUD_DIV + 1) : 12;
    localparam logic [BCW-1:0] BAUD_LAST = BCW'(BAUD_DIV - 1);
    localparam logic [BCW-1:0] BAUD_HALF = BCW'(BAUD_DIV / 2);

    // ---------------- transmit side ----------------
    typedef enum logic [1:0] {TX_IDLE, TX_HIGH, TX_LOW} tx_state_t;

    tx_state_t      tx_state_reg, tx_state_next;
    logic [7:0]     cmd_lo_reg;
    logic [9:0]     tx_shift_reg;
    logic [BCW-1:0] tx_baud_reg;
    logic [3:0]     tx_bit_reg;
    logic           cmd_snt_reg;
    logic           tx_accept, tx_load_low, tx_done;
    logic           tx_bit_end, tx_frame_end;

    assign tx_bit_end   = (tx_baud_reg == BAUD_LAST);
    assign tx_frame_end = tx_bit_end && (tx_bit_reg == 4'd9);

    always_comb begin
        tx_state_next = tx_state_reg;
        tx_accept     = 1'b0;
        tx_load_low   = 1'b0;
        tx_done       = 1'b0;
        case (tx_state_reg)
            TX_IDLE: begin
                if (bus.snd_cmd) begin
                    tx_accept     = 1'b1;
                    tx_state_next = TX_HIGH;
                end
            end
            TX_HIGH: begin
                if (tx_frame_end) begin
                    tx_load_low   = 1'b1;
                    tx_state_next = TX_LOW;
                end
            end
            TX_LOW: begin
                if (tx_frame_end) begin
                    tx_done       = 1'b1;
                    tx_state_next = TX_IDLE;
                end
            end
            default: tx_state_next = TX_IDLE;
        endcase
    end

    // The high byte goes straight into the frame, so only the low byte needs holding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_reg <= TX_IDLE;
            cmd_lo_reg   <= 8'h00;
            tx_shift_reg <= '1;
            tx_baud_reg  <= '0;
            tx_bit_reg   <= 4'd0;
            cmd_snt_reg  <= 1'b0;
        end else begin
            tx_state_reg <= tx_state_next;
            if (tx_accept) begin
                cmd_lo_reg   <= bus.cmd[7:0];
                cmd_snt_reg  <= 1'b0;
                tx_shift_reg <= {1'b1, bus.cmd[15:8], 1'b0};
                tx_baud_reg  <= '0;
                tx_bit_reg   <= 4'd0;
            end else if (tx_load_low) begin
                tx_shift_reg <= {1'b1, cmd_lo_reg, 1'b0};
                tx_baud_reg  <= '0;
                tx_bit_reg   <= 4'd0;
            end else if (tx_state_reg != TX_IDLE) begin
                if (tx_bit_end) begin
                    tx_baud_reg  <= '0;
                    tx_bit_reg   <= tx_bit_reg + 4'd1;
                    tx_shift_reg <= {1'b1, tx_shift_reg[9:1]};
                end else begin
                    tx_baud_reg <= tx_baud_reg + BCW'(1);
                end
            end
            if (tx_done) begin
                cmd_snt_reg <= 1'b1;
            end
        end
    end

    assign bus.TX      = tx_shift_reg[0];
    assign bus.cmd_snt = cmd_snt_reg;

    // ---------------- receive side ----------------
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t      rx_state_reg, rx_state_next;
    logic           rx_sync1_reg, rx_sync2_reg, rx_prev_reg;
    logic [BCW-1:0] rx_baud_reg;
    logic [3:0]     rx_bit_reg;
    logic [7:0]     rx_shift_reg;
    logic [7:0]     resp_reg;
    logic           resp_rdy_reg;
    logic           rx_begin, rx_good, rx_tick, rx_fall;

    assign rx_fall = rx_prev_reg & ~rx_sync2_reg;
    assign rx_tick = (rx_baud_reg == '0);

    always_comb begin
        rx_state_next = rx_state_reg;
        rx_begin      = 1'b0;
        rx_good       = 1'b0;
        case (rx_state_reg)
            RX_IDLE: begin
                if (rx_fall) begin
                    rx_begin      = 1'b1;
                    rx_state_next = RX_START;
                end
            end
            RX_START: begin
                if (rx_tick) begin
                    rx_state_next = rx_sync2_reg ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_tick && (rx_bit_reg == 4'd7)) begin
                    rx_state_next = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_tick) begin
                    rx_good       = rx_sync2_reg;
                    rx_state_next = RX_IDLE;
                end
            end
            default: rx_state_next = RX_IDLE;
        endcase
    end

    // Synchronizer and edge detector preset high so leaving reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_reg <= RX_IDLE;
            rx_sync1_reg <= 1'b1;
            rx_sync2_reg <= 1'b1;
            rx_prev_reg  <= 1'b1;
            rx_baud_reg  <= '0;
            rx_bit_reg   <= 4'd0;
            rx_shift_reg <= 8'h00;
            resp_reg     <= 8'h00;
            resp_rdy_reg <= 1'b0;
        end else begin
            rx_state_reg <= rx_state_next;
            rx_sync1_reg <= bus.RX;
            rx_sync2_reg <= rx_sync1_reg;
            rx_prev_reg  <= rx_sync2_reg;
            if (rx_begin) begin
                rx_baud_reg <= BAUD_HALF;
                rx_bit_reg  <= 4'd0;
            end else if (rx_state_reg != RX_IDLE) begin
                if (rx_tick) begin
                    rx_baud_reg <= BAUD_LAST;
                    if (rx_state_reg == RX_DATA) begin
                        rx_shift_reg <= {rx_sync2_reg, rx_shift_reg[7:1]};
                        rx_bit_reg   <= rx_bit_reg + 4'd1;
                    end
                end else begin
                    rx_baud_reg <= rx_baud_reg - BCW'(1);
                end
            end
            if (rx_good) begin
                resp_reg     <= rx_shift_reg;
                resp_rdy_reg <= 1'b1;
            end else if (rx_begin || bus.clr_resp_rdy) begin
                resp_rdy_reg <= 1'b0;
            end
        end
    end

    assign bus.resp     = resp_reg;
    assign bus.resp_rdy = resp_rdy_reg;

    // ---------------- optional response watchdog ----------------
`ifdef RESP_TIMEOUT_EN
    localparam logic [21:0] TO_LAST = 22'(TIMEOUT_CLKS - 1);

    logic [21:0] to_cnt_reg;
    logic        to_active_reg;
    logic        resp_timeout_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_reg       <= 22'd0;
            to_active_reg    <= 1'b0;
            resp_timeout_reg <= 1'b0;
        end else if (tx_accept) begin
            to_cnt_reg       <= 22'd0;
            to_active_reg    <= 1'b0;
            resp_timeout_reg <= 1'b0;
        end else if (tx_done) begin
            to_cnt_reg    <= 22'd0;
            to_active_reg <= 1'b1;
        end else if (rx_good) begin
            to_cnt_reg    <= 22'd0;
            to_active_reg <= 1'b0;
        end else if (to_active_reg) begin
            if (to_cnt_reg == TO_LAST) begin
                resp_timeout_reg <= 1'b1;
                to_active_reg    <= 1'b0;
            end else begin
                to_cnt_reg <= to_cnt_reg + 22'd1;
            end
        end
    end

    assign bus.resp_timeout = resp_timeout_reg;
`else
    assign bus.resp_timeout = 1'b0;
`endif

endmodule
